// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and capture blocks.
package pwm_pkg;

    // Default sample width and frame size (log2 of clocks per frame).
    localparam int PWM_N = 25;
    localparam int PWM_W = 20;

    // Capture state machine encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, plus a delay stage
// that yields a single-cycle rising-edge pulse in the synchronized domain.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic s,
    output logic rise
);

    logic meta;
    logic s_q;
    logic s_d;

    // Synchronizer chain and edge-detect delay flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            s_q  <= 1'b0;
            s_d  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let each flop take the previous stage's old value, forming a true shift chain.
            meta <= async_in;
            s_q  <= meta;
            s_d  <= s_q;
        end
    end

    assign s    = s_q;
    assign rise = s_q & ~s_d;

endmodule

// File: rtl/pwm_capture.sv
// Recovers one sample per fixed 2^W-clock PWM frame by counting high
// cycles, and presents it on a held ready/ack handshake with sticky
// overrun and frame-sync error flags.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int N = PWM_N,
    parameter int W = PWM_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         pwm_in,
    input  logic         ack,
    output logic [N-1:0] data_out,
    output logic         ready,
    output logic         overrun,
    output logic         sync_err
);

    localparam logic [W-1:0] POS_LAST = '1;

    pwm_state_e   state;
    pwm_state_e   state_nxt;
    logic [W-1:0] pos;
    logic [W-1:0] pos_nxt;
    logic [W:0]   hcnt;
    logic [W:0]   hcnt_nxt;
    logic [N-1:0] data_nxt;
    logic         ready_nxt;
    logic         overrun_nxt;
    logic         sync_err_nxt;

    logic         s;
    logic         rise;
    logic [W:0]   h_total;
    logic [W-1:0] sample;
    logic         frame_end;

    sync_edge u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pwm_in),
        .s        (s),
        .rise     (rise)
    );

    // High-cycle total including the current cycle, and the decoded sample
    // (d+1 high cycles decode to d; an all-low frame decodes to 0).
    always_comb begin
        h_total = hcnt + {{W{1'b0}}, s};
        sample  = (h_total == '0) ? '0 : W'(h_total - (W+1)'(1));
    end

    // Next state, frame position and high-count accumulation.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a signal unassigned and infers a latch.
        state_nxt    = state;
        pos_nxt      = pos;
        hcnt_nxt     = hcnt;
        sync_err_nxt = sync_err;
        frame_end    = 1'b0;

        if (!enable) begin
            state_nxt    = ST_IDLE;
            pos_nxt      = '0;
            hcnt_nxt     = '0;
            sync_err_nxt = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    pos_nxt   = '0;
                    hcnt_nxt  = '0;
                    state_nxt = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        pos_nxt   = W'(1);
                        hcnt_nxt  = (W+1)'(1);
                        state_nxt = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (rise && (pos != '0)) begin
                        // Edge inside a frame: lose lock and drop the frame.
                        sync_err_nxt = 1'b1;
                        pos_nxt      = '0;
                        hcnt_nxt     = '0;
                        state_nxt    = ST_ARM;
                    end else if (pos == POS_LAST) begin
                        frame_end = 1'b1;
                        pos_nxt   = '0;
                        hcnt_nxt  = '0;
                    end else begin
                        pos_nxt  = pos + W'(1);
                        hcnt_nxt = h_total;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Sample delivery and consumer handshake.
    always_comb begin
        data_nxt    = data_out;
        ready_nxt   = ready;
        overrun_nxt = overrun;

        if (frame_end) begin
            data_nxt  = N'(sample);
            ready_nxt = 1'b1;
            // An unacknowledged sample being replaced is an overrun; an ack
            // landing on the same cycle consumes the old one cleanly.
            if (ready) begin
                overrun_nxt = ~ack;
            end
        end else if (ready && ack) begin
            ready_nxt   = 1'b0;
            overrun_nxt = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            pos      <= '0;
            hcnt     <= '0;
            data_out <= '0;
            ready    <= 1'b0;
            overrun  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            pos      <= pos_nxt;
            hcnt     <= hcnt_nxt;
            data_out <= data_nxt;
            ready    <= ready_nxt;
            overrun  <= overrun_nxt;
            sync_err <= sync_err_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture with 16-clock frames (W=4, N=8).
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int TN    = 8;
    localparam int TW    = 4;
    localparam int FRAME = 1 << TW;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic          enable = 1'b0;
    logic          pwm_in = 1'b0;
    logic          ack    = 1'b0;
    logic [TN-1:0] data_out;
    logic          ready;
    logic          overrun;
    logic          sync_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    pwm_capture #(.N(TN), .W(TW)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .pwm_in   (pwm_in),
        .ack      (ack),
        .data_out (data_out),
        .ready    (ready),
        .overrun  (overrun),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: the decoder sees the input two clocks late; a
    // frame is the 16 consecutive synchronized bits starting at a rise,
    // and its sample is (number of ones) - 1, floored at 0.
    // ---------------------------------------------------------------
    bit            m_p1, m_p2, m_p3;   // pwm_in one, two, three edges ago
    int            m_phase;            // 0 disabled, 1 hunting for a rise, 2 inside frames
    bit            m_win[$];           // synchronized bits of the current frame
    logic [TN-1:0] m_data  = '0;
    bit            m_ready = 1'b0;
    bit            m_ovr   = 1'b0;
    bit            m_err   = 1'b0;

    always @(posedge clk or posedge reset) begin
        bit ms;
        bit mrise;
        bit emit;
        int highs;
        if (reset) begin
            m_p1 = 0; m_p2 = 0; m_p3 = 0;
            m_phase = 0;
            m_win.delete();
            m_data = '0; m_ready = 0; m_ovr = 0; m_err = 0;
        end else begin
            ms    = m_p2;
            mrise = m_p2 && !m_p3;
            emit  = 0;
            highs = 0;
            if (!enable) begin
                m_phase = 0;
                m_win.delete();
                m_err = 0;
            end else if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (mrise) begin
                    m_win.delete();
                    m_win.push_back(ms);
                    m_phase = 2;
                end
            end else begin
                if (mrise && m_win.size() != 0) begin
                    m_err = 1;
                    m_win.delete();
                    m_phase = 1;
                end else begin
                    m_win.push_back(ms);
                    if (m_win.size() == FRAME) begin
                        foreach (m_win[i]) highs += int'(m_win[i]);
                        emit = 1;
                        m_win.delete();
                    end
                end
            end
            if (emit) begin
                if (m_ready) m_ovr = !ack;
                m_data  = TN'((highs == 0) ? 0 : highs - 1);
                m_ready = 1;
            end else if (ack && m_ready) begin
                m_ready = 0;
                m_ovr   = 0;
            end
            m_p3 = m_p2; m_p2 = m_p1; m_p1 = pwm_in;
        end
    end

    // Cycle-by-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_data", data_out, m_data);
            check("cyc_ready", ready, m_ready);
            check("cyc_overrun", overrun, m_ovr);
            check("cyc_sync_err", sync_err, m_err);
        end
    end

    // One clock of stimulus; returns 1 time unit after the edge that used it.
    task automatic step(input bit p, input bit en, input bit a);
        pwm_in = p;
        enable = en;
        ack    = a;
        @(posedge clk);
        #1;
    endtask

    // Return to ARM with a low line and no pending sample.
    task automatic resync();
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 1);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d3[3];
        int d;
        int glitch;
        int dis;
        bit p;
        bit a;
        bit en;

        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_on = 1'b1;

        check("rst_data", data_out, 0);
        check("rst_ready", ready, 0);
        check("rst_overrun", overrun, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_state", dut.state, ST_IDLE);

        // 6 high + 10 low decodes to 5; ready exactly 17 clocks after the rise input.
        resync();
        for (int i = 0; i < 19; i++) begin
            step(i <= 5, 1, i == 18);
            if (i == 16) check("d5_not_yet", ready, 0);
            if (i == 17) begin
                check("d5_ready", ready, 1);
                check("d5_data", data_out, 5);
            end
            if (i == 18) check("d5_acked", ready, 0);
        end

        // All-high frame, then 1 high + 15 low, then steady all-high.
        resync();
        for (int i = 0; i < 96; i++) begin
            step((i < 17) || (i >= 48), 1, i == 40);
            if (i == 17) check("full_data", data_out, 15);
            if (i == 33) begin
                check("one_data", data_out, 0);
                check("one_overrun", overrun, 1);
            end
        end
        check("steady_high_no_err", sync_err, 0);
        check("steady_high_data", data_out, 15);

        // Two frames without ack: overrun, then one ack clears both.
        resync();
        for (int i = 0; i < 34; i++) begin
            step((i < 16) ? (i <= 3) : (i - 16 <= 9), 1, 0);
        end
        check("ovr_data", data_out, 9);
        check("ovr_flag", overrun, 1);
        step(0, 1, 1);
        check("ovr_ack_ready", ready, 0);
        check("ovr_ack_flag", overrun, 0);

        // Ack landing exactly on a frame-end cycle.
        resync();
        d3[0] = 7; d3[1] = 2; d3[2] = 11;
        for (int i = 0; i < 50; i++) begin
            step((i < 48) && ((i % FRAME) <= d3[i / FRAME]), 1, i == 49);
            if (i == 33) check("fe_ack_pre_ovr", overrun, 1);
        end
        check("fe_ack_data", data_out, 11);
        check("fe_ack_ready", ready, 1);
        check("fe_ack_overrun", overrun, 0);

        // Extra rise at pos 7: frame dropped, ARM, next frame decodes.
        resync();
        for (int i = 0; i < 36; i++) begin
            if (i < 16) step((i <= 2) || (i == 7) || (i == 8), 1, 0);
            else        step((i >= 18) && (i <= 22), 1, 0);
            if (i == 9) begin
                check("glitch_err", sync_err, 1);
                check("glitch_state", dut.state, ST_ARM);
            end
            if (i == 17) check("glitch_no_sample", ready, 0);
        end
        check("post_glitch_data", data_out, 4);
        check("post_glitch_ready", ready, 1);

        // Reset mid-frame clears everything at once; reacquire needs a new rise.
        resync();
        for (int i = 0; i < 27; i++) begin
            step((i < 16) ? (i <= 8) : (i - 16 <= 5), 1, 0);
        end
        check("pre_rst_ready", ready, 1);
        pwm_in = 1'b0;
        reset  = 1'b1;
        #1;
        check("mid_rst_data", data_out, 0);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_state", dut.state, ST_IDLE);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 21; i++) begin
            step((i >= 3) && (i <= 9), 1, 0);
            if (i == 19) check("reacq_not_yet", ready, 0);
        end
        check("reacq_ready", ready, 1);
        check("reacq_data", data_out, 6);

        // Enable dropped mid-frame: partial frame lost, data kept, sync_err cleared.
        step(0, 1, 1);
        for (int i = 0; i < 41; i++) begin
            step((i <= 1) || ((i >= 6) && (i <= 13)), !((i >= 14) && (i <= 16)), 0);
            if (i == 13) check("drop_err_sticky", sync_err, 1);
            if (i == 16) begin
                check("drop_err_clr", sync_err, 0);
                check("drop_data_kept", data_out, 6);
            end
        end
        check("drop_no_sample", ready, 0);
        check("drop_data_final", data_out, 6);

        // Randomized frames with acks, glitches, enable drops and gaps.
        for (int f = 0; f < 150; f++) begin
            d = int'($urandom_range(0, FRAME - 1));
            glitch = -1;
            if ((d <= FRAME - 3) && ($urandom_range(0, 9) == 0))
                glitch = int'($urandom_range(d + 2, FRAME - 1));
            dis = -1;
            if ($urandom_range(0, 19) == 0) dis = int'($urandom_range(1, FRAME));
            for (int i = 0; i < FRAME; i++) begin
                p  = (i <= d) || (i == glitch);
                a  = ($urandom_range(0, 7) == 0);
                en = 1'b1;
                if ((dis >= 0) && (i >= dis) && (i < dis + 3)) begin
                    en = 1'b0;
                    a  = 1'b0;
                end
                step(p, en, a);
            end
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(1, 20)) step(0, 1, 0);
            end
        end

        step(0, 1, 0);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
